// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the CPU32 datapath, arbitrating the single RAM port.
// Optional performance counters are enabled with `define SEQ_PERF_CNT_EN.
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        excp,
  input  logic        reg_wr,
  input  logic        reg_src_ram,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_we,
  output logic        reg_we,
  output logic        retire,
  output logic [1:0]  fault,
  output logic [2:0]  state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] inst_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam bit             TO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

  state_t          cur;
  state_t          nxt;
  logic [TO_W-1:0] to_cnt;
  logic            pending;
  logic            timed_out;
  logic            entering;
  logic [1:0]      fault_nxt;

  assign state     = cur;
  assign timed_out = TO_EN && (to_cnt == TO_LAST) && !mem_ack;
  assign entering  = (nxt != cur) && ((nxt == FETCH) || (nxt == MEM));

  // pending marks a fetch request already on the bus, which run=0 must not abandon
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= IDLE;
      fault   <= 2'd0;
      to_cnt  <= '0;
      pending <= 1'b0;
    end else begin
      cur     <= nxt;
      fault   <= fault_nxt;
      pending <= (cur == FETCH) && (nxt == FETCH);
      if (entering || (mem_req && mem_ack))
        to_cnt <= '0;
      else if (mem_req)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    nxt       = cur;
    fault_nxt = fault;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_we    = 1'b0;
    reg_we    = 1'b0;
    retire    = 1'b0;
    case (cur)
      IDLE: begin
        if (run) nxt = FETCH;
      end
      FETCH: begin
        if (!pending && !run) begin
          nxt = IDLE;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
            nxt   = DECODE;
          end else if (timed_out) begin
            fault_nxt = 2'd2;
            nxt       = FAULT;
          end
        end
      end
      DECODE: begin
        if (excp) begin
          fault_nxt = 2'd1;
          nxt       = FAULT;
        end else begin
          nxt = EXEC;
        end
      end
      EXEC: begin
        alu_we = 1'b1;
        if (is_jump) begin
          pc_we  = 1'b1;
          pc_sel = 2'd2;
          retire = 1'b1;
          nxt    = FETCH;
        end else if (is_branch) begin
          retire = 1'b1;
          nxt    = FETCH;
          if (br_taken) begin
            pc_we  = 1'b1;
            pc_sel = 2'd1;
          end
        end else if (is_store || reg_src_ram) begin
          nxt = MEM;
        end else if (reg_wr) begin
          nxt = WB;
        end else begin
          retire = 1'b1;
          nxt    = FETCH;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_store) begin
            retire = 1'b1;
            nxt    = FETCH;
          end else begin
            nxt = WB;
          end
        end else if (timed_out) begin
          fault_nxt = 2'd2;
          nxt       = FAULT;
        end
      end
      WB: begin
        reg_we = 1'b1;
        retire = 1'b1;
        nxt    = FETCH;
      end
      FAULT: begin
        nxt = FAULT;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  // Both counters wrap naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= 32'd0;
      inst_cnt <= 32'd0;
    end else begin
      if ((cur != IDLE) && (cur != FAULT))
        cyc_cnt <= cyc_cnt + 32'd1;
      if (retire)
        inst_cnt <= inst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus randomized instructions
// checked against a per-instruction cycle/strobe model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        excp = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_src_ram = 1'b0;
  logic        is_store = 1'b0;
  logic        is_branch = 1'b0;
  logic        is_jump = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_sel, mem_we, ir_we, pc_we, alu_we, reg_we, retire;
  logic [1:0]  pc_sel, fault;
  logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt, inst_cnt;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          fetch_delay = 0;
  int          data_delay = 0;
  int          wait_cnt = 0;
  logic        stray_ack = 1'b0;
  int          exp_ret_total = 0;
  int          exp_cyc_total = 0;
  logic [2:0]  alu_states [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

  cpu_sequencer #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .run(run), .excp(excp), .reg_wr(reg_wr),
    .reg_src_ram(reg_src_ram), .is_store(is_store), .is_branch(is_branch),
    .is_jump(is_jump), .br_taken(br_taken), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_we(alu_we), .reg_we(reg_we),
    .retire(retire), .fault(fault), .state(state)
`ifdef SEQ_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM responder: acks after a programmed number of wait cycles per request
  always begin
    @(posedge clk);
    #2;
    if (rst || !mem_req) begin
      wait_cnt = 0;
      mem_ack  = stray_ack;
    end else if (wait_cnt >= (mem_sel ? data_delay : fetch_delay)) begin
      mem_ack  = 1'b1;
      wait_cnt = 0;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rw, input logic rsr, input logic st,
                               input logic br, input logic jp, input logic bt,
                               input logic ex);
    reg_wr      = rw;
    reg_src_ram = rsr;
    is_store    = st;
    is_branch   = br;
    is_jump     = jp;
    br_taken    = bt;
    excp        = ex;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-instruction model: cycle length and strobe counts follow from the instruction class
  task automatic runInstr(input string tag, input logic rw, input logic rsr, input logic st,
                          input logic br, input logic jp, input logic bt,
                          input int fd, input int dd);
    bit mem_op, wb_op;
    int n;
    int c_ir = 0, c_pc0 = 0, c_pc1 = 0, c_pc2 = 0, c_alu = 0;
    int c_reg = 0, c_ret = 0, c_data = 0, c_we = 0;
    mem_op = !jp && !br && (st || rsr);
    wb_op  = !jp && !br && ((mem_op && !st) || (!mem_op && rw));
    n = (fd + 1) + 2 + (mem_op ? dd + 1 : 0) + (wb_op ? 1 : 0);
    applyStimulus(rw, rsr, st, br, jp, bt, 1'b0);
    fetch_delay = fd;
    data_delay  = dd;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput({tag, "_start_state"}, 32'(state), 32'd1);
      c_ir   += int'(ir_we);
      c_pc0  += int'(pc_we && pc_sel == 2'd0);
      c_pc1  += int'(pc_we && pc_sel == 2'd1);
      c_pc2  += int'(pc_we && pc_sel == 2'd2);
      c_alu  += int'(alu_we);
      c_reg  += int'(reg_we);
      c_ret  += int'(retire);
      c_data += int'(mem_req && mem_sel);
      c_we   += int'(mem_req && mem_we);
      tick();
    end
    checkOutput({tag, "_ir_we"},   32'(c_ir),   32'd1);
    checkOutput({tag, "_pc_seq"},  32'(c_pc0),  32'd1);
    checkOutput({tag, "_pc_br"},   32'(c_pc1),  32'(br && bt && !jp));
    checkOutput({tag, "_pc_jmp"},  32'(c_pc2),  32'(jp));
    checkOutput({tag, "_alu_we"},  32'(c_alu),  32'd1);
    checkOutput({tag, "_reg_we"},  32'(c_reg),  32'(wb_op));
    checkOutput({tag, "_retire"},  32'(c_ret),  32'd1);
    checkOutput({tag, "_data"},    32'(c_data), 32'(mem_op ? dd + 1 : 0));
    checkOutput({tag, "_mem_we"},  32'(c_we),   32'((mem_op && st) ? dd + 1 : 0));
    checkOutput({tag, "_fault"},   32'(fault),  32'd0);
    exp_ret_total++;
    exp_cyc_total += n;
  endtask

  initial begin
    int rets;
    int bad;
    logic [31:0] r;

    #1 rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_state",   32'(state),   32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_fault",   32'(fault),   32'd0);
    checkOutput("rst_retire",  32'(retire),  32'd0);

    // ALU op with zero-wait RAM, cycle-by-cycle from reset release
    tick();
    rst = 1'b0;
    run = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rets = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("alu_state_c%0d", c), 32'(state), 32'(alu_states[c-1]));
      checkOutput($sformatf("alu_reg_we_c%0d", c), 32'(reg_we), 32'(c == 5));
      rets += int'(retire);
      tick();
    end
    checkOutput("alu_retire_cnt", 32'(rets), 32'd1);
    exp_ret_total = 1;
    exp_cyc_total = 4;

    runInstr("load_wait3",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
    runInstr("br_taken",     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    runInstr("br_not_taken", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    runInstr("jump",         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    runInstr("jump_prio",    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 2);
    runInstr("store",        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 2);
    runInstr("nop",          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    runInstr("fetch_wait3",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    for (int k = 0; k < 24; k++) begin
      r = $urandom;
      runInstr($sformatf("rnd%0d", k), r[0], r[1], r[2], r[3] & r[4], r[5] & r[6], r[7],
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
`ifdef SEQ_PERF_CNT_EN
    checkOutput("perf_inst_cnt", inst_cnt, 32'(exp_ret_total));
    checkOutput("perf_cyc_cnt",  cyc_cnt,  32'(exp_cyc_total));
`endif

    // Illegal instruction: sticky fault, immune to run and stray acks
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch_delay = 0;
    @(negedge clk);
    checkOutput("excp_fetch_state", 32'(state), 32'd1);
    tick();
    tick();
    @(negedge clk);
    checkOutput("excp_state", 32'(state), 32'd6);
    checkOutput("excp_fault", 32'(fault), 32'd1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      run       = 1'($urandom);
      stray_ack = 1'($urandom);
      @(negedge clk);
      if (state !== 3'd6 || fault !== 2'd1 || mem_req || ir_we || pc_we || alu_we ||
          reg_we || retire)
        bad++;
    end
    checkOutput("excp_hold_violations", 32'(bad), 32'd0);
    tick();
    rst       = 1'b1;
    run       = 1'b0;
    stray_ack = 1'b0;
    @(negedge clk);
    checkOutput("excp_rst_state", 32'(state), 32'd0);
    checkOutput("excp_rst_fault", 32'(fault), 32'd0);

    // Fetch timeout: four request cycles without ack
    tick();
    rst = 1'b0;
    run = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch_delay = 7;
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("to_fetch_req_c%0d", c), 32'(mem_req), 32'd1);
      tick();
    end
    @(negedge clk);
    checkOutput("to_fetch_state", 32'(state),   32'd6);
    checkOutput("to_fetch_fault", 32'(fault),   32'd2);
    checkOutput("to_fetch_req",   32'(mem_req), 32'd0);

    // Data-access timeout on a load
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch_delay = 0;
    data_delay  = 7;
    repeat (4) tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("to_mem_req_c%0d", c), 32'(mem_req && mem_sel), 32'd1);
      tick();
    end
    @(negedge clk);
    checkOutput("to_mem_state", 32'(state), 32'd6);
    checkOutput("to_mem_fault", 32'(fault), 32'd2);

    // Asynchronous reset in the middle of a data request
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checkOutput("amem_req_before", 32'(mem_req && mem_sel), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("amem_req_async",   32'(mem_req), 32'd0);
    checkOutput("amem_state_async", 32'(state),   32'd0);
    tick();
    rst       = 1'b0;
    run       = 1'b0;
    stray_ack = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (state !== 3'd0 || mem_req || ir_we || pc_we || retire || fault !== 2'd0) bad++;
      tick();
    end
    checkOutput("stray_ack_idle", 32'(bad), 32'd0);
    stray_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the CPU32 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback, using the decoded control-path fields of the current instruction.
- Arbitrates the single RAM port between instruction fetch and load/store data access.
- Sits between the instruction decoder, the PC/IR/ALU-output registers, the register file and RAM.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ack per request; 0 disables the timeout
TO_W, 5, width of the timeout counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  enable; the FSM leaves IDLE only while high
excp  in  1  decoder exception flag (illegal opcode)
reg_wr  in  1  decoded register-write enable
reg_src_ram  in  1  decoded "writeback from RAM" (load)
is_store  in  1  instruction is sb/sh/sw
is_branch  in  1  instruction is a conditional branch
is_jump  in  1  instruction is j
br_taken  in  1  branch condition true; sampled in EXEC
mem_ack  in  1  RAM completes current request this cycle
mem_req  out  1  RAM request, held until ack
mem_sel  out  1  0 = instruction address (PC), 1 = data address (ALU out)
mem_we  out  1  RAM write strobe, valid with mem_req
ir_we  out  1  load IR from RAM data
pc_we  out  1  PC update strobe
pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = reserved
alu_we  out  1  latch ALU result into ALU-out register
reg_we  out  1  register-file write strobe
retire  out  1  one-cycle pulse when an instruction completes
fault  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout; sticky
state  out  3  current state, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. Encoding 7 is unreachable and returns to IDLE.
- Outputs are combinational from state and inputs, except fault and the timeout counter, which are registered.
- Reset (async, any state, mid-request included):
  - state goes to IDLE; fault = 0; counter = 0.
  - All strobes and mem_req are 0 while rst is high.
  - An outstanding RAM request is abandoned; a late mem_ack outside FETCH/MEM is ignored.
- IDLE: all strobes 0. If run = 1, go to FETCH next cycle.
- FETCH: mem_req=1, mem_sel=0, mem_we=0.
  - On mem_ack: ir_we=1, pc_we=1, pc_sel=0 in the same cycle; go to DECODE.
  - If run = 0 and no request is outstanding (first FETCH cycle), go to IDLE instead of requesting.
  - Once a request is issued it is held until ack or timeout.
- DECODE: one cycle, no strobes. If excp = 1, set fault=1 and go to FAULT; else go to EXEC.
- EXEC: one cycle, alu_we=1. Priority of next action:
  1. is_jump: pc_we=1, pc_sel=2, retire=1, go to FETCH.
  2. is_branch: retire=1, go to FETCH. If br_taken, also pc_we=1, pc_sel=1.
  3. is_store or reg_src_ram: go to MEM.
  4. reg_wr: go to WB.
  5. Otherwise: retire=1, go to FETCH.
- MEM: mem_req=1, mem_sel=1, mem_we=is_store.
  - On ack, load: go to WB.
  - On ack, store: retire=1, go to FETCH.
- WB: reg_we=1, retire=1, go to FETCH.
- FAULT: all strobes 0. Remains until rst; run is ignored.
- Timeout counter:
  - Clears on entry to FETCH or MEM, and on every ack.
  - Increments each cycle that mem_req=1 and mem_ack=0.
  - When MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with no ack: fault=2, go to FAULT next cycle, mem_req drops.
  - If the ack arrives in that same cycle, the ack wins.
- Cycle counts:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB) with zero-wait RAM.
  - Load: 5 cycles. Store: 4. Branch/jump: 3.
- Fields decoded from IR (excp, reg_wr, etc.) are sampled only in DECODE, EXEC and MEM; they are don't-care elsewhere.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined:
  - Extra outputs cyc_cnt[31:0] and inst_cnt[31:0].
  - cyc_cnt increments every cycle state != IDLE and != FAULT.
  - inst_cnt increments on each retire pulse.
  - Both wrap modulo 2^32 and clear on rst.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- rst pulse, then run=1, zero-wait RAM, ALU op (reg_wr=1) -> states 0,1,2,3,5,1; reg_we high exactly in cycle 5 after rst release; retire pulses once.
- Load (reg_src_ram=1, reg_wr=1) with mem_ack delayed 3 cycles in MEM -> mem_sel=1 and mem_we=0 for 4 cycles; then WB with reg_we=1; total 8 cycles FETCH to FETCH.
- Taken branch (br_taken=1) -> pc_we=1, pc_sel=1 in EXEC; not taken -> pc_we=0 in EXEC; both return to FETCH and retire once.
- excp=1 in DECODE -> fault=1, state=6; run toggling and mem_ack have no effect for 20 cycles; rst returns to IDLE with fault=0.
- MEM_TIMEOUT=4, mem_ack held 0 in FETCH -> mem_req high 4 cycles, then fault=2, state=6. Repeat with ack on the 4th cycle -> no fault, goes to DECODE.
- Assert rst mid-MEM while mem_req=1 -> mem_req=0 immediately (async); after release, state=0; a stray mem_ack in IDLE does nothing.
